dphy_lane_sequencer: RTL

- Per-lane HS-entry controller and byte aligner in the dphy_clk domain.
- Watches the lane's LP lines, sequences the Stop → HS-Request → Bridge → HS-settle entry, and enables HS termination.
- Searches the 2-bit-per-clock DDR stream for the 0xB8 sync byte at either bit offset, then emits aligned LSB-first bytes with a valid strobe every 4 dphy_clk cycles until the lane returns to Stop.

---
 rtl/dphy_lane_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dphy_lane_sequencer.sv
// Per-lane D-PHY HS-entry sequencer: LP-line state tracking, HS termination control
// and 0xB8 sync search over a 2-bit-per-clock DDR stream, then LSB-first byte delivery.
module dphy_lane_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 24,
  parameter int unsigned SYNC_TIMEOUT  = 255
) (
  input  logic       dphy_clk,
  input  logic       areset,
  input  logic       enable,
  input  logic       lp_p,
  input  logic       lp_n,
  input  logic [1:0] din,
  output logic       hs_term_en,
  output logic       hs_active,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       sync_error
);

  // state       | meaning
  // IDLE        | lane disabled or waiting for LP-11
  // STOP        | LP-11 seen, waiting for LP-01
  // HS_RQST     | LP-01 seen, waiting for LP-00 (bridge)
  // HS_SETTLE   | termination on, waiting for the receiver to settle
  // SYNC_SEARCH | hunting for 0xB8 at either bit offset
  // HS_RX       | aligned, emitting one byte every 4 clocks
  // WAIT_STOP   | sync lost, waiting for the lane to return to LP-11
  typedef enum logic [2:0] {
    IDLE,
    STOP,
    HS_RQST,
    HS_SETTLE,
    SYNC_SEARCH,
    HS_RX,
    WAIT_STOP
  } state_t;

  localparam logic [7:0] SYNC_BYTE    = 8'hB8;
  localparam logic [9:0] SETTLE_LOAD  = 10'(SETTLE_CYCLES - 1);
  localparam logic [9:0] TIMEOUT_LOAD = 10'(SYNC_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        p_meta;
  logic        p_sync;
  logic        n_meta;
  logic        n_sync;
  logic [1:0]  lp;
  logic [9:0]  sr;
  logic [7:0]  win0;
  logic [7:0]  win1;
  logic        match0;
  logic        match1;
  logic [9:0]  tmr;
  logic [1:0]  phase;
  logic        offset;
  logic        byte_due;

  assign lp     = {p_sync, n_sync};
  assign win0   = sr[9:2];
  assign win1   = sr[8:1];
  assign match0 = (win0 == SYNC_BYTE);
  assign match1 = (win1 == SYNC_BYTE);

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      p_meta <= 1'b0;
      p_sync <= 1'b0;
      n_meta <= 1'b0;
      n_sync <= 1'b0;
    end else begin
      p_meta <= lp_p;
      p_sync <= p_meta;
      n_meta <= lp_n;
      n_sync <= n_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (lp == 2'b11) state_nxt = STOP;
      end
      STOP: begin
        if (lp == 2'b01) state_nxt = HS_RQST;
      end
      HS_RQST: begin
        // LP-10 would be escape entry, which this lane does not support
        if (lp == 2'b00) state_nxt = HS_SETTLE;
        else if (lp == 2'b11 || lp == 2'b10) state_nxt = STOP;
      end
      HS_SETTLE: begin
        if (tmr == '0) state_nxt = SYNC_SEARCH;
      end
      SYNC_SEARCH: begin
        if (match1 || match0) state_nxt = HS_RX;
        else if (tmr == '0) state_nxt = WAIT_STOP;
      end
      HS_RX: begin
        if (lp == 2'b11) state_nxt = STOP;
      end
      WAIT_STOP: begin
        if (lp == 2'b11) state_nxt = STOP;
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  assign byte_due = (state == HS_RX) && (state_nxt == HS_RX) && (phase == 2'd3);

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      sr    <= {din[1], din[0], sr[9:2]};
    end
  end

  // One shared down-counter times both the settle window and the sync timeout.
  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      tmr <= '0;
    end else if (state_nxt == HS_SETTLE && state != HS_SETTLE) begin
      tmr <= SETTLE_LOAD;
    end else if (state_nxt == SYNC_SEARCH && state != SYNC_SEARCH) begin
      tmr <= TIMEOUT_LOAD;
    end else if (tmr != '0) begin
      tmr <= tmr - 10'd1;
    end
  end

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      phase  <= '0;
      offset <= 1'b0;
    end else if (state == SYNC_SEARCH && state_nxt == HS_RX) begin
      phase  <= '0;
      offset <= match1;
    end else if (state == HS_RX) begin
      phase  <= phase + 2'd1;
    end
  end

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      hs_term_en <= 1'b0;
      hs_active  <= 1'b0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      hs_term_en <= (state_nxt == HS_SETTLE) || (state_nxt == SYNC_SEARCH) ||
                    (state_nxt == HS_RX);
      hs_active  <= (state_nxt == HS_RX);
      byte_valid <= byte_due;
      sync_error <= (state == SYNC_SEARCH) && (state_nxt == WAIT_STOP);
      if (byte_due) byte_out <= offset ? win1 : win0;
    end
  end

endmodule
